// File: rtl/intersection_ctrl.sv
// Two-approach intersection phase scheduler: NS/EW green arbitration with min/max green, yellow, all-red and pedestrian WALK.
// Optional emergency preemption is compiled in when the PREEMPT_EN macro is defined.
module intersection_ctrl #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 4,
    parameter int unsigned PED_CLR_T = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ns_car_det,
    input  logic        ew_car_det,
    input  logic        ns_ped_btn,
    input  logic        ew_ped_btn,
    input  logic        preempt_req,
    input  logic        preempt_ns,
    output logic [1:0]  ns_car,
    output logic [1:0]  ew_car,
    output logic [1:0]  ns_hmn,
    output logic [1:0]  ew_hmn,
    output logic [2:0]  phase,
    output logic [15:0] timer
);

    localparam int unsigned TW = 16;
    localparam int unsigned PED_END = WALK_T + PED_CLR_T;

    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

    localparam logic [1:0] CAR_RED   = 2'b00;
    localparam logic [1:0] CAR_YEL   = 2'b01;
    localparam logic [1:0] CAR_GRN   = 2'b10;
    localparam logic [1:0] HMN_DONT  = 2'b00;
    localparam logic [1:0] HMN_FLASH = 2'b01;
    localparam logic [1:0] HMN_WALK  = 2'b10;

    typedef enum logic [2:0] {
        AR_NS = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR_EW = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5
    } phase_t;

    phase_t          r_state;
    phase_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_ns_ped_pend;
    logic            r_ew_ped_pend;
    logic            w_ns_pend_nxt;
    logic            w_ew_pend_nxt;
    logic            r_walk_srv;
    logic            w_walk_srv_nxt;
    logic [1:0]      r_ns_car;
    logic [1:0]      r_ew_car;
    logic [1:0]      r_ns_hmn;
    logic [1:0]      r_ew_hmn;
    logic [1:0]      w_ns_car_nxt;
    logic [1:0]      w_ew_car_nxt;
    logic [1:0]      w_ns_hmn_nxt;
    logic [1:0]      w_ew_hmn_nxt;
    logic            w_phase_chg;
    logic            w_ns_dem;
    logic            w_ew_dem;
    logic            w_ns_exit;
    logic            w_ew_exit;
    logic            w_ns_cut;
    logic            w_ew_cut;
    logic            w_ped_cut_nxt;

    // Pedestrian head during a served green, indexed by the green's elapsed time.
    function automatic logic [1:0] ped_head(input logic srv, input logic [TW-1:0] t);
        logic [1:0] h;
        h = HMN_DONT;
        if (srv) begin
            if (32'(t) < WALK_T) begin
                h = HMN_WALK;
            end else if (32'(t) < PED_END) begin
                h = HMN_FLASH;
            end
        end
        return h;
    endfunction

    assign w_ns_dem = ns_car_det | r_ns_ped_pend;
    assign w_ew_dem = ew_car_det | r_ew_ped_pend;

`ifdef PREEMPT_EN
    logic r_ped_cut;

    assign w_ns_cut  = preempt_req & ~preempt_ns;
    assign w_ew_cut  = preempt_req &  preempt_ns;
    // A preempted direction's green is held; the other green is cut regardless of GREEN_MIN.
    assign w_ns_exit = w_ns_cut | (~w_ew_cut & (r_timer >= T_GMIN) & w_ew_dem &
                                   (~ns_car_det | (r_timer >= T_GMAX)));
    assign w_ew_exit = w_ew_cut | (~w_ns_cut & (r_timer >= T_GMIN) & w_ns_dem &
                                   (~ew_car_det | (r_timer >= T_GMAX)));
`else
    logic w_unused_preempt;

    assign w_unused_preempt = preempt_req ^ preempt_ns;
    assign w_ns_cut  = 1'b0;
    assign w_ew_cut  = 1'b0;
    assign w_ns_exit = (r_timer >= T_GMIN) & w_ew_dem & (~ns_car_det | (r_timer >= T_GMAX));
    assign w_ew_exit = (r_timer >= T_GMIN) & w_ns_dem & (~ew_car_det | (r_timer >= T_GMAX));
`endif

    // Next phase, timer, pedestrian bookkeeping and the registered light values.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_ns_pend_nxt  = r_ns_ped_pend | ns_ped_btn;
        w_ew_pend_nxt  = r_ew_ped_pend | ew_ped_btn;
        w_walk_srv_nxt = r_walk_srv;
        w_ped_cut_nxt  = 1'b0;
        w_ns_car_nxt   = CAR_RED;
        w_ew_car_nxt   = CAR_RED;
        w_ns_hmn_nxt   = HMN_DONT;
        w_ew_hmn_nxt   = HMN_DONT;

        case (r_state)
            AR_NS:   if (r_timer == T_AR)  w_state_nxt = NS_G;
            NS_G:    if (w_ns_exit)        w_state_nxt = NS_Y;
            NS_Y:    if (r_timer == T_YEL) w_state_nxt = AR_EW;
            AR_EW:   if (r_timer == T_AR)  w_state_nxt = EW_G;
            EW_G:    if (w_ew_exit)        w_state_nxt = EW_Y;
            EW_Y:    if (r_timer == T_YEL) w_state_nxt = AR_NS;
            default:                       w_state_nxt = AR_NS;
        endcase

        w_phase_chg = (w_state_nxt != r_state);

        if (w_phase_chg) begin
            w_timer_nxt = '0;
        end else if (r_timer != '1) begin
            w_timer_nxt = r_timer + TW'(1);
        end

        // Entering a green captures its latch (plus a same-cycle press) and clears it.
        if (w_phase_chg && w_state_nxt == NS_G) begin
            w_walk_srv_nxt = r_ns_ped_pend | ns_ped_btn;
            w_ns_pend_nxt  = 1'b0;
        end
        if (w_phase_chg && w_state_nxt == EW_G) begin
            w_walk_srv_nxt = r_ew_ped_pend | ew_ped_btn;
            w_ew_pend_nxt  = 1'b0;
        end

`ifdef PREEMPT_EN
        if (!w_phase_chg) begin
            w_ped_cut_nxt = r_ped_cut;
        end
        if (r_state == NS_G && w_state_nxt == NS_Y && w_ns_cut && r_ns_hmn != HMN_DONT) begin
            w_ped_cut_nxt = 1'b1;
        end
        if (r_state == EW_G && w_state_nxt == EW_Y && w_ew_cut && r_ew_hmn != HMN_DONT) begin
            w_ped_cut_nxt = 1'b1;
        end
`endif

        case (w_state_nxt)
            NS_G: begin
                w_ns_car_nxt = CAR_GRN;
                w_ns_hmn_nxt = ped_head(w_walk_srv_nxt, w_timer_nxt);
            end
            NS_Y: begin
                w_ns_car_nxt = CAR_YEL;
                if (w_ped_cut_nxt) w_ns_hmn_nxt = HMN_FLASH;
            end
            EW_G: begin
                w_ew_car_nxt = CAR_GRN;
                w_ew_hmn_nxt = ped_head(w_walk_srv_nxt, w_timer_nxt);
            end
            EW_Y: begin
                w_ew_car_nxt = CAR_YEL;
                if (w_ped_cut_nxt) w_ew_hmn_nxt = HMN_FLASH;
            end
            default: begin
                w_ns_car_nxt = CAR_RED;
                w_ew_car_nxt = CAR_RED;
            end
        endcase
    end

    // State, timer, latches and registered light outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= AR_NS;
            r_timer       <= '0;
            r_ns_ped_pend <= 1'b0;
            r_ew_ped_pend <= 1'b0;
            r_walk_srv    <= 1'b0;
            r_ns_car      <= CAR_RED;
            r_ew_car      <= CAR_RED;
            r_ns_hmn      <= HMN_DONT;
            r_ew_hmn      <= HMN_DONT;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_ns_ped_pend <= w_ns_pend_nxt;
            r_ew_ped_pend <= w_ew_pend_nxt;
            r_walk_srv    <= w_walk_srv_nxt;
            r_ns_car      <= w_ns_car_nxt;
            r_ew_car      <= w_ew_car_nxt;
            r_ns_hmn      <= w_ns_hmn_nxt;
            r_ew_hmn      <= w_ew_hmn_nxt;
        end
    end

`ifdef PREEMPT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_cut <= 1'b0;
        end else begin
            r_ped_cut <= w_ped_cut_nxt;
        end
    end
`endif

    assign ns_car = r_ns_car;
    assign ew_car = r_ew_car;
    assign ns_hmn = r_ns_hmn;
    assign ew_hmn = r_ew_hmn;
    assign phase  = r_state;
    assign timer  = r_timer;

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-approach intersection phase scheduler. Owns the single shared right-of-way and grants it alternately to the north-south (NS) and east-west (EW) approaches based on vehicle-detector and pedestrian-button demand. Drives both approaches' 2-bit vehicle and pedestrian signal buses using the same encoding as the per-approach `tra` light heads. Enforces minimum/maximum green, yellow and all-red clearance.

## Interface
- `GREEN_MIN`, 8: minimum green length, cycles (≥ `WALK_T` + `PED_CLR_T`, ≥ 1)
- `GREEN_MAX`, 20: maximum green when both approaches have demand, cycles (≥ `GREEN_MIN`)
- `YELLOW_T`, 3: yellow length, cycles (≥ 1)
- `ALLRED_T`, 2: all-red clearance length, cycles (≥ 1)
- `WALK_T`, 4: pedestrian WALK length, cycles (≥ 1)
- `PED_CLR_T`, 3: pedestrian flashing-clearance length, cycles (≥ 1)
- All timing parameters must be ≤ 65535.

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `ns_car_det` in 1: NS vehicle present (level)
- `ew_car_det` in 1: EW vehicle present (level)
- `ns_ped_btn` in 1: NS crosswalk button (pulse or level)
- `ew_ped_btn` in 1: EW crosswalk button
- `preempt_req` in 1: emergency preemption request (used only with `PREEMPT_EN`)
- `preempt_ns` in 1: preemption direction, 1 = NS, 0 = EW
- `ns_car`, `ew_car` out 2: 00 red, 01 yellow, 10 green
- `ns_hmn`, `ew_hmn` out 2: 00 don't walk, 01 flashing clearance, 10 walk
- `phase` out 3: 0 AR_NS, 1 NS_G, 2 NS_Y, 3 AR_EW, 4 EW_G, 5 EW_Y
- `timer` out 16: cycles elapsed in the current phase

## Operation
- Six-state FSM, order AR_NS → NS_G → NS_Y → AR_EW → EW_G → EW_Y → AR_NS.
- `timer` is 0 in a phase's first cycle, increments each cycle, saturates at 16'hFFFF, and clears on every phase change.
- AR_x lasts `ALLRED_T` cycles. x_Y lasts `YELLOW_T` cycles. A phase advances on the edge where `timer == T-1`.
- Pedestrian latches `ns_ped_pend` and `ew_ped_pend`:
  - A latch sets on any cycle its button is high.
  - At entry to x_G, the latch value is captured into `walk_srv` and the latch is cleared. A button high in that same cycle is absorbed by this green.
  - A press during x_G re-sets the latch and is served on the next x green.
- Demand for an approach = its car detector OR its pedestrian latch.
- x_G exit to x_Y happens on the edge after a cycle in which all of the following hold:
  - `timer ≥ GREEN_MIN-1`
  - cross demand is present
  - own car detector is low OR `timer ≥ GREEN_MAX-1`
- Without cross demand, green rests indefinitely.
- Car outputs:
  - x_G: green on x, red on the cross approach.
  - x_Y: yellow on x, red on the cross approach.
  - AR_*: both red.
- Pedestrian outputs during x_G with `walk_srv` = 1:
  - x_hmn = walk for `timer` in [0, `WALK_T`)
  - x_hmn = flashing for `timer` in [`WALK_T`, `WALK_T`+`PED_CLR_T`)
  - x_hmn = don't walk afterwards
- All other cases: x_hmn = don't walk. Cross-approach hmn is always don't walk.

## Timing
- All outputs are registered and change only on the clock edge that changes `phase` or `timer`.
- Reset, asserted at any time including mid-green or mid-yellow, immediately and asynchronously forces:
  - `phase` = AR_NS, `timer` = 0
  - all car outputs red, all hmn outputs don't walk
  - pedestrian latches and `walk_srv` cleared
- First NS green is the `ALLRED_T`-th cycle after reset release.
- A detector change is seen by the exit decision on the next edge. Yellow therefore starts at the earliest one cycle after the condition holds.

## Configuration
- `PREEMPT_EN` defined:
  - While `preempt_req` = 1, green toward the direction that is not preempted ends immediately, ignoring `GREEN_MIN`. It then runs full yellow and all-red.
  - Green toward the preempted direction is held while `preempt_req` = 1, regardless of `GREEN_MAX`.
  - Any WALK on the opposing approach is cut to flashing for the remaining yellow.
  - Normal sequencing resumes on the edge after `preempt_req` falls.
- `PREEMPT_EN` undefined: `preempt_req` and `preempt_ns` are ignored and no preemption logic is synthesized.

## Test plan
All scenarios use the default parameters.
- Reset release, no demand → cycles 0-1 all red, `ns_car` = 10 from cycle 2 and held for 100 cycles; `ew_car` = 00 throughout.
- `ew_car_det` = 1 held, `ns_car_det` = 0 → NS green 8 cycles, yellow 3, all-red 2, then `ew_car` = 10.
- Both detectors held high → each green lasts exactly 20 cycles; full period = 2×(20+3+2) = 50 cycles.
- One-cycle `ew_ped_btn` pulse during NS green → EW green entry gives `ew_hmn` = 10 for 4 cycles, then 01 for 3, then 00. The latch is cleared.
- Reset asserted at NS_Y `timer` = 1 → outputs all red immediately, `phase` = 0; after release NS green again `ALLRED_T` cycles later.
- `PREEMPT_EN`, `preempt_req` = 1 with `preempt_ns` = 0 at NS green `timer` = 2 → NS yellow on next edge, EW green 5 cycles later, held until the request drops.
